// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - sequential instruction prefetcher with redirect and prefetch queue
// Keeps one memory request in flight while queue space remains; redirects flush and drop stale data.
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    output logic [1:0]        memctl_op,
    output logic [1:0]        memctl_len,
    output logic [ADDR_W-1:0] memctl_addr,
    input  logic              memctl_rdy,
    input  logic [INST_W-1:0] memctl_out,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [2:0]        stall
);
    localparam logic [1:0] MEM_NOP  = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [2:0] STALL_IF = 3'b001;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        op_q, len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic              push, pop, room;
    logic [ADDR_W-1:0] jump_target, pc_inc;

    always_comb begin
        pop         = (count_q != '0) && out_ready;
        push        = (state_q == REQ) && memctl_rdy;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        room        = count_d < CNT_W'(DEPTH);
        jump_target = {jump_addr[ADDR_W-1:2], 2'b00};
        pc_inc      = fetch_pc_q + ADDR_W'(4);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            op_q       <= MEM_NOP;
            len_q      <= 2'b00;
            addr_q     <= '0;
        end else if (rdy_in) begin
            if (jump_en) begin
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= jump_target;
                case (state_q)
                    // A request already on the bus must complete before the target can be issued.
                    REQ, DISCARD: begin
                        if (memctl_rdy) begin
                            state_q <= REQ;
                            addr_q  <= jump_target;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end
                    default: begin
                        state_q <= REQ;
                        op_q    <= MEM_LOAD;
                        len_q   <= MEM_WORD;
                        addr_q  <= jump_target;
                    end
                endcase
            end else begin
                count_q <= count_d;
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case (state_q)
                    IDLE: begin
                        if (room) begin
                            state_q <= REQ;
                            op_q    <= MEM_LOAD;
                            len_q   <= MEM_WORD;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    REQ: begin
                        if (memctl_rdy) begin
                            fetch_pc_q <= pc_inc;
                            if (room) begin
                                addr_q <= pc_inc;
                            end else begin
                                state_q <= IDLE;
                                op_q    <= MEM_NOP;
                                len_q   <= 2'b00;
                            end
                        end
                    end
                    DISCARD: begin
                        if (memctl_rdy) begin
                            state_q <= REQ;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && !jump_en && push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= memctl_out;
        end
    end

    assign memctl_op   = op_q;
    assign memctl_len  = len_q;
    assign memctl_addr = addr_q;
    assign out_valid   = count_q != '0;
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign out_inst    = inst_mem_q[rd_ptr_q];
    assign stall       = out_valid ? 3'b000 : STALL_IF;
endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - directed self-checking bench for if_prefetch
// Memory returns addr ^ 32'hDEADBEEF so every delivered word can be tied to its address.
module tb_if_prefetch;
    localparam logic [1:0] MEM_NOP  = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [2:0] STALL_IF = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_in = 1'b1;
    logic [1:0]  memctl_op, memctl_len;
    logic [31:0] memctl_addr;
    logic        memctl_rdy = 1'b0;
    logic [31:0] memctl_out = '0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst;
    logic [2:0]  stall;

    int checks = 0;
    int passes = 0;

    if_prefetch dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in),
        .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
        .memctl_rdy(memctl_rdy), .memctl_out(memctl_out),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request/response round trip; optionally checks the head it produced.
    task automatic serve(input logic [31:0] a, input bit check_head);
        chk("req_addr", memctl_addr, a);
        chk("req_op", 32'(memctl_op), 32'(MEM_LOAD));
        memctl_rdy = 1'b1;
        memctl_out = word(a);
        step();
        memctl_rdy = 1'b0;
        if (check_head) begin
            chk("head_pc", out_pc, a);
            chk("head_inst", out_inst, word(a));
        end
        step();
    endtask

    initial begin
        // reset
        step(); step();
        chk("rst_op", 32'(memctl_op), 32'(MEM_NOP));
        chk("rst_len", 32'(memctl_len), 32'h0);
        chk("rst_addr", memctl_addr, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'(STALL_IF));

        // test 1: streaming with consumer always ready
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t1_len", 32'(memctl_len), 32'(MEM_WORD));
        serve(32'h0, 1'b1);
        serve(32'h4, 1'b1);
        serve(32'h8, 1'b1);

        // test 2: consumer stalled fills the queue
        out_ready = 1'b0;
        serve(32'hC, 1'b0);
        serve(32'h10, 1'b0);
        serve(32'h14, 1'b0);
        serve(32'h18, 1'b0);
        chk("t2_full_op", 32'(memctl_op), 32'(MEM_NOP));
        chk("t2_full_len", 32'(memctl_len), 32'h0);
        chk("t2_stall", 32'(stall), 32'h0);
        chk("t2_head", out_pc, 32'hC);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_refill_op", 32'(memctl_op), 32'(MEM_LOAD));
        chk("t2_refill_addr", memctl_addr, 32'h1C);
        chk("t2_next_head", out_pc, 32'h10);

        // test 3: redirect while request pending -> DISCARD
        jump_en = 1'b1;
        jump_addr = 32'h103;
        step();
        jump_en = 1'b0;
        chk("t3_flush_valid", 32'(out_valid), 32'h0);
        chk("t3_flush_stall", 32'(stall), 32'(STALL_IF));
        chk("t3_hold_addr", memctl_addr, 32'h1C);
        step();
        chk("t3_hold_addr2", memctl_addr, 32'h1C);
        memctl_rdy = 1'b1;
        memctl_out = word(32'h1C);
        step();
        memctl_rdy = 1'b0;
        chk("t3_dropped", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        serve(32'h100, 1'b1);

        // test 4: redirect coincident with response and pop
        out_ready = 1'b0;
        serve(32'h104, 1'b0);
        chk("t4_pre_valid", 32'(out_valid), 32'h1);
        jump_en = 1'b1;
        jump_addr = 32'h200;
        memctl_rdy = 1'b1;
        memctl_out = word(32'h108);
        out_ready = 1'b1;
        step();
        jump_en = 1'b0;
        memctl_rdy = 1'b0;
        chk("t4_empty", 32'(out_valid), 32'h0);
        chk("t4_target", memctl_addr, 32'h200);
        chk("t4_op", 32'(memctl_op), 32'(MEM_LOAD));
        step();
        chk("t4_no_stale", 32'(out_valid), 32'h0);
        serve(32'h200, 1'b1);

        // test 5: address wrap and concurrent push/pop
        jump_en = 1'b1;
        jump_addr = 32'hFFFFFFF9;
        memctl_rdy = 1'b1;
        memctl_out = word(32'h204);
        step();
        jump_en = 1'b0;
        memctl_rdy = 1'b0;
        out_ready = 1'b0;
        serve(32'hFFFFFFF8, 1'b0);
        serve(32'hFFFFFFFC, 1'b0);
        serve(32'h0, 1'b0);
        serve(32'h4, 1'b0);
        chk("t5_full_op", 32'(memctl_op), 32'(MEM_NOP));
        chk("t5_head", out_pc, 32'hFFFFFFF8);
        out_ready = 1'b1;
        step();
        chk("t5_pop1", out_pc, 32'hFFFFFFFC);
        chk("t5_req8", memctl_addr, 32'h8);
        memctl_rdy = 1'b1;
        memctl_out = word(32'h8);
        step();
        memctl_rdy = 1'b0;
        chk("t5_pushpop_head", out_pc, 32'h0);
        chk("t5_pushpop_addr", memctl_addr, 32'hC);
        step();
        chk("t5_pop3", out_pc, 32'h4);
        step();
        chk("t5_pop4_pc", out_pc, 32'h8);
        chk("t5_pop4_inst", out_inst, word(32'h8));
        step();
        chk("t5_drained", 32'(out_valid), 32'h0);

        // test 6: async reset mid-request, late response ignored
        chk("t6_pending", 32'(memctl_op), 32'(MEM_LOAD));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_op", 32'(memctl_op), 32'(MEM_NOP));
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_addr", memctl_addr, 32'h0);
        memctl_rdy = 1'b1;
        memctl_out = word(32'hC);
        step();
        rst_n = 1'b1;
        step();
        memctl_rdy = 1'b0;
        chk("t6_idle_rdy_ignored", 32'(out_valid), 32'h0);
        chk("t6_restart_addr", memctl_addr, 32'h0);

        // global enable low freezes everything, including memctl_rdy
        rdy_in = 1'b0;
        memctl_rdy = 1'b1;
        memctl_out = word(32'h0);
        step();
        memctl_rdy = 1'b0;
        chk("frz_valid", 32'(out_valid), 32'h0);
        chk("frz_addr", memctl_addr, 32'h0);
        rdy_in = 1'b1;
        serve(32'h0, 1'b1);
        chk("frz_resume_addr", memctl_addr, 32'h4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
